// File: rtl/synch_pkg.sv
// Shared types and helpers for the synchronized-input glitch filter and event detector.
package synch_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_QUAL   = 1'b1
  } flt_state_t;

  // Qualification counter width: enough to hold FLT_CNT-1, never narrower than one bit.
  function automatic int qcnt_width(input int flt_cnt);
    return (flt_cnt <= 2) ? 1 : $clog2(flt_cnt);
  endfunction

endpackage

// File: rtl/synch_glitch_filter.sv
// Single-bit glitch filter: accepts a new level after FLT_CNT consecutive differing
// samples and emits a one-cycle rise or fall pulse on acceptance.
module synch_glitch_filter
  import synch_pkg::*;
#(
  parameter int FLT_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int             QW   = qcnt_width(FLT_CNT);
  localparam logic [QW-1:0]  QMAX = QW'(FLT_CNT - 1);

  flt_state_t      state_q, state_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic            filt_q, filt_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
    state_d = ST_STABLE;
    qcnt_d  = '0;
    filt_d  = filt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    // A matching sample falls through to the defaults, discarding any partial qualification.
    if (din_i != filt_q) begin
      if (qcnt_q == QMAX) begin
        filt_d = din_i;
        rise_d = din_i;
        fall_d = ~din_i;
      end else begin
        state_d = ST_QUAL;
        qcnt_d  = (state_q == ST_QUAL) ? qcnt_q + 1'b1 : QW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STABLE;
      qcnt_q  <= '0;
      filt_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      filt_q  <= filt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/synch_event_detect.sv
// Per-bit glitch filter and edge detector downstream of the sink-domain synchronizer,
// with sticky edge flags and a saturating event counter.
module synch_event_detect
  import synch_pkg::*;
#(
  parameter int DAT_WID = 1,
  parameter int FLT_CNT = 4,
  parameter int EVT_WID = 8
) (
  input  logic               sink_clk,
  input  logic               sink_rst_n,
  input  logic [DAT_WID-1:0] sync_dat,
  input  logic               stky_clr,
  input  logic               evt_clr,
  output logic [DAT_WID-1:0] filt_dat,
  output logic [DAT_WID-1:0] rise_pls,
  output logic [DAT_WID-1:0] fall_pls,
  output logic [DAT_WID-1:0] rise_stky,
  output logic [DAT_WID-1:0] fall_stky,
  output logic [EVT_WID-1:0] evt_cnt
);

  for (genvar g = 0; g < DAT_WID; g++) begin : g_flt
    synch_glitch_filter #(
      .FLT_CNT (FLT_CNT)
    ) u_flt (
      .clk    (sink_clk),
      .rst_n  (sink_rst_n),
      .din_i  (sync_dat[g]),
      .filt_o (filt_dat[g]),
      .rise_o (rise_pls[g]),
      .fall_o (fall_pls[g])
    );
  end

  logic               any_evt;
  logic [DAT_WID-1:0] rise_stky_q, rise_stky_d;
  logic [DAT_WID-1:0] fall_stky_q, fall_stky_d;
  logic [EVT_WID-1:0] evt_cnt_q, evt_cnt_d;

  assign any_evt = |(rise_pls | fall_pls);

  always_comb begin
    // Set beats clear when both land in the same cycle.
    rise_stky_d = (rise_stky_q & ~{DAT_WID{stky_clr}}) | rise_pls;
    fall_stky_d = (fall_stky_q & ~{DAT_WID{stky_clr}}) | fall_pls;

    evt_cnt_d = evt_cnt_q;
    if (evt_clr) begin
      evt_cnt_d = EVT_WID'(any_evt);
    end else if (any_evt && (evt_cnt_q != '1)) begin
      evt_cnt_d = evt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sink_clk or negedge sink_rst_n) begin
    if (!sink_rst_n) begin
      rise_stky_q <= '0;
      fall_stky_q <= '0;
      evt_cnt_q   <= '0;
    end else begin
      rise_stky_q <= rise_stky_d;
      fall_stky_q <= fall_stky_d;
      evt_cnt_q   <= evt_cnt_d;
    end
  end

  assign rise_stky = rise_stky_q;
  assign fall_stky = fall_stky_q;
  assign evt_cnt   = evt_cnt_q;

endmodule

// File: tb/tb_synch_event_detect.sv
// Bench for synch_event_detect: a 4-bit FLT_CNT=4 EVT_WID=2 instance and a 1-bit FLT_CNT=1
// instance, checked against a sample-history reference model.
module tb_synch_event_detect;

  localparam int FA = 4;
  localparam int FB = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sync_a = '0;
  logic       sync_b = 1'b0;
  logic       stky_clr = 1'b0;
  logic       evt_clr = 1'b0;

  logic [3:0] filt_a, rise_a, fall_a, rstky_a, fstky_a;
  logic [1:0] evt_a;
  logic       filt_b, rise_b, fall_b, rstky_b, fstky_b;
  logic [7:0] evt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  synch_event_detect #(.DAT_WID(4), .FLT_CNT(FA), .EVT_WID(2)) u_dut_a (
    .sink_clk   (clk),
    .sink_rst_n (rst_n),
    .sync_dat   (sync_a),
    .stky_clr   (stky_clr),
    .evt_clr    (evt_clr),
    .filt_dat   (filt_a),
    .rise_pls   (rise_a),
    .fall_pls   (fall_a),
    .rise_stky  (rstky_a),
    .fall_stky  (fstky_a),
    .evt_cnt    (evt_a)
  );

  synch_event_detect #(.DAT_WID(1), .FLT_CNT(FB), .EVT_WID(8)) u_dut_b (
    .sink_clk   (clk),
    .sink_rst_n (rst_n),
    .sync_dat   (sync_b),
    .stky_clr   (stky_clr),
    .evt_clr    (evt_clr),
    .filt_dat   (filt_b),
    .rise_pls   (rise_b),
    .fall_pls   (fall_b),
    .rise_stky  (rstky_b),
    .fall_stky  (fstky_b),
    .evt_cnt    (evt_b)
  );

  // Reference model: a level is accepted when the last N samples all differ from it.
  logic [3:0] m_filt_a, m_rise_a, m_fall_a, m_rstky_a, m_fstky_a;
  logic       m_filt_b, m_rise_b, m_fall_b, m_rstky_b, m_fstky_b;
  int         m_evt_a, m_evt_b;
  bit         hist_a[4][$];
  bit         hist_b[$];

  function automatic bit accept(input bit q[$], input int n, input bit filt);
    if (q.size() != n) return 1'b0;
    foreach (q[i]) if (q[i] == filt) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int next_evt(input int cur, input bit any, input bit clr, input int maxv);
    if (clr) return any ? 1 : 0;
    if (any) return (cur < maxv) ? cur + 1 : maxv;
    return cur;
  endfunction

  task automatic model_reset();
    m_filt_a = '0; m_rise_a = '0; m_fall_a = '0; m_rstky_a = '0; m_fstky_a = '0; m_evt_a = 0;
    m_filt_b = 0;  m_rise_b = 0;  m_fall_b = 0;  m_rstky_b = 0;  m_fstky_b = 0;  m_evt_b = 0;
    foreach (hist_a[i]) hist_a[i].delete();
    hist_b.delete();
  endtask

  task automatic model_edge();
    // Sticky flags and counter see the pulses that were visible before this edge.
    m_rstky_a = stky_clr ? m_rise_a : (m_rstky_a | m_rise_a);
    m_fstky_a = stky_clr ? m_fall_a : (m_fstky_a | m_fall_a);
    m_evt_a   = next_evt(m_evt_a, |(m_rise_a | m_fall_a), evt_clr, 3);
    m_rstky_b = stky_clr ? m_rise_b : (m_rstky_b | m_rise_b);
    m_fstky_b = stky_clr ? m_fall_b : (m_fstky_b | m_fall_b);
    m_evt_b   = next_evt(m_evt_b, m_rise_b | m_fall_b, evt_clr, 255);

    for (int i = 0; i < 4; i++) begin
      m_rise_a[i] = 1'b0;
      m_fall_a[i] = 1'b0;
      hist_a[i].push_back(sync_a[i]);
      if (hist_a[i].size() > FA) void'(hist_a[i].pop_front());
      if (accept(hist_a[i], FA, m_filt_a[i])) begin
        m_filt_a[i] = ~m_filt_a[i];
        if (m_filt_a[i]) m_rise_a[i] = 1'b1;
        else             m_fall_a[i] = 1'b1;
      end
    end

    m_rise_b = 1'b0;
    m_fall_b = 1'b0;
    hist_b.push_back(sync_b);
    if (hist_b.size() > FB) void'(hist_b.pop_front());
    if (accept(hist_b, FB, m_filt_b)) begin
      m_filt_b = ~m_filt_b;
      if (m_filt_b) m_rise_b = 1'b1;
      else          m_fall_b = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sync_a = 4'b0001; sync_b = 1'b1; stky_clr = 1'b0; evt_clr = 1'b0;
    model_reset();
    repeat (2) tick();
    checks++;
    if ({filt_a, rise_a, fall_a, rstky_a, fstky_a, evt_a, filt_b, rise_b, fall_b, rstky_b, fstky_b, evt_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got a=%h b=%h expected 0", {filt_a, rise_a, fall_a, rstky_a, fstky_a, evt_a},
               {filt_b, rise_b, fall_b, rstky_b, fstky_b, evt_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (filt_a[0] !== (k >= 4) || rise_a[0] !== (k == 4)) begin
        errors++;
        $display("FAIL reset_latency_a edge %0d got filt=%b rise=%b expected filt=%b rise=%b",
                 k, filt_a[0], rise_a[0], k >= 4, k == 4);
      end
      checks++;
      if (filt_b !== 1'b1 || rise_b !== (k == 1)) begin
        errors++;
        $display("FAIL flt1_follow edge %0d got filt=%b rise=%b expected filt=1 rise=%b", k, filt_b, rise_b, k == 1);
      end
    end
    checks++;
    if (evt_a !== 2'd1 || rstky_a !== 4'b0001 || evt_b !== 8'd1) begin
      errors++;
      $display("FAIL reset_first_event got evt_a=%0d rstky_a=%b evt_b=%0d expected 1 0001 1", evt_a, rstky_a, evt_b);
    end
  endtask

  task automatic test_glitch();
    sync_a[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (filt_a[1] !== 1'b0 || rise_a !== 4'b0000) begin
        errors++;
        $display("FAIL glitch_hold got filt=%b rise=%b expected 0 0000", filt_a[1], rise_a);
      end
    end
    sync_a[1] = 1'b0;
    repeat (4) tick();
    checks++;
    if (filt_a !== 4'b0001 || evt_a !== 2'd1 || (rise_a | fall_a) !== 4'b0000) begin
      errors++;
      $display("FAIL glitch_reject got filt=%b evt=%0d pls=%b expected 0001 1 0000", filt_a, evt_a, rise_a | fall_a);
    end
  endtask

  task automatic test_saturation();
    for (int t = 0; t < 5; t++) begin
      sync_a[0] = ~sync_a[0];
      repeat (5) tick();
    end
    checks++;
    if (evt_a !== 2'd3 || filt_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL evt_saturate got evt=%0d filt0=%b expected 3 0", evt_a, filt_a[0]);
    end
    sync_a[0] = 1'b1;
    repeat (4) tick();
    checks++;
    if (rise_a !== 4'b0001) begin
      errors++;
      $display("FAIL pulse_before_clr got rise=%b expected 0001", rise_a);
    end
    evt_clr = 1'b1;
    tick();
    evt_clr = 1'b0;
    checks++;
    if (evt_a !== 2'd1) begin
      errors++;
      $display("FAIL evt_clr_with_event got %0d expected 1", evt_a);
    end
  endtask

  task automatic test_sticky();
    stky_clr = 1'b1;
    tick();
    stky_clr = 1'b0;
    tick();
    checks++;
    if (rstky_a !== 4'b0000 || fstky_a !== 4'b0000) begin
      errors++;
      $display("FAIL sticky_clear got r=%b f=%b expected 0000 0000", rstky_a, fstky_a);
    end
    sync_a[0] = 1'b0;
    repeat (4) tick();
    checks++;
    if (fall_a !== 4'b0001) begin
      errors++;
      $display("FAIL fall_pulse got %b expected 0001", fall_a);
    end
    stky_clr = 1'b1;
    tick();
    checks++;
    if (fstky_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set_wins got %b expected 1", fstky_a[0]);
    end
    tick();
    stky_clr = 1'b0;
    checks++;
    if (fstky_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clr_next got %b expected 0", fstky_a[0]);
    end
  endtask

  task automatic test_multibit();
    evt_clr = 1'b1;
    tick();
    evt_clr = 1'b0;
    checks++;
    if (evt_a !== 2'd0) begin
      errors++;
      $display("FAIL evt_clr_alone got %0d expected 0", evt_a);
    end
    sync_a = 4'b0101;
    repeat (4) tick();
    checks++;
    if (rise_a !== 4'b0101) begin
      errors++;
      $display("FAIL multibit_pulses got %b expected 0101", rise_a);
    end
    tick();
    checks++;
    if (evt_a !== 2'd1) begin
      errors++;
      $display("FAIL multibit_one_event got %0d expected 1", evt_a);
    end
    sync_a[3] = 1'b1;
    repeat (4) tick();
    checks++;
    if (rise_a !== 4'b1000) begin
      errors++;
      $display("FAIL bit3_pulse got %b expected 1000", rise_a);
    end
    tick();
    checks++;
    if (evt_a !== 2'd2) begin
      errors++;
      $display("FAIL bit3_event got %0d expected 2", evt_a);
    end
  endtask

  task automatic test_reset_mid();
    sync_a = 4'b0000;
    sync_b = 1'b0;
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({filt_a, rise_a, fall_a, rstky_a, fstky_a, evt_a, filt_b, rise_b, fall_b, rstky_b, fstky_b, evt_b} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async got a=%h b=%h expected 0", {filt_a, rise_a, fall_a, rstky_a, fstky_a, evt_a},
               {filt_b, rise_b, fall_b, rstky_b, fstky_b, evt_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({filt_a, rise_a, fall_a, evt_a, filt_b, rise_b, fall_b, evt_b} !== '0) begin
        errors++;
        $display("FAIL reset_release_quiet cycle %0d got a=%h b=%h expected 0", k,
                 {filt_a, rise_a, fall_a, evt_a}, {filt_b, rise_b, fall_b, evt_b});
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 6) == 0) sync_a[i] = ~sync_a[i];
      sync_b   = 1'($urandom_range(0, 1));
      stky_clr = ($urandom_range(0, 15) == 0);
      evt_clr  = ($urandom_range(0, 31) == 0);
      tick();
      checks++;
      if ({filt_a, rise_a, fall_a, rstky_a, fstky_a, evt_a} !==
          {m_filt_a, m_rise_a, m_fall_a, m_rstky_a, m_fstky_a, 2'(m_evt_a)}) begin
        errors++;
        $display("FAIL random_a cycle %0d got %h expected %h", c, {filt_a, rise_a, fall_a, rstky_a, fstky_a, evt_a},
                 {m_filt_a, m_rise_a, m_fall_a, m_rstky_a, m_fstky_a, 2'(m_evt_a)});
      end
      checks++;
      if ({filt_b, rise_b, fall_b, rstky_b, fstky_b, evt_b} !==
          {m_filt_b, m_rise_b, m_fall_b, m_rstky_b, m_fstky_b, 8'(m_evt_b)}) begin
        errors++;
        $display("FAIL random_b cycle %0d got %h expected %h", c, {filt_b, rise_b, fall_b, rstky_b, fstky_b, evt_b},
                 {m_filt_b, m_rise_b, m_fall_b, m_rstky_b, m_fstky_b, 8'(m_evt_b)});
      end
    end
    stky_clr = 1'b0;
    evt_clr  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_saturation();
    test_sticky();
    test_multibit();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/synch_event_detect.md
# synch_event_detect

Per-bit glitch filter and edge/event detector. It sits directly downstream of the multi-flop `synch` synchronizer in the sink clock domain and consumes its already-synchronized `sink_dat` bus. It accepts a new level only after it has been stable for `FLT_CNT` consecutive samples, and emits one-cycle rise/fall pulses for each accepted change. It also keeps sticky edge flags and a saturating event counter for software or status logic.

## Interface
- `DAT_WID`, 1: number of independent bits filtered (≥1)
- `FLT_CNT`, 4: consecutive differing samples needed to accept a new level (≥1)
- `EVT_WID`, 8: event counter width (≥1)

- `sink_clk`  in  1  sink-domain clock; single clock for the whole block
- `sink_rst_n`  in  1  asynchronous, active-low reset
- `sync_dat`  in  DAT_WID  synchronized input level from the synchronizer stage
- `stky_clr`  in  1  clears all sticky flags
- `evt_clr`  in  1  clears event counter
- `filt_dat`  out  DAT_WID  filtered (accepted) level
- `rise_pls`  out  DAT_WID  one-cycle pulse per accepted 0→1 change
- `fall_pls`  out  DAT_WID  one-cycle pulse per accepted 1→0 change
- `rise_stky`  out  DAT_WID  sticky rise flags
- `fall_stky`  out  DAT_WID  sticky fall flags
- `evt_cnt`  out  EVT_WID  saturating count of cycles with any accepted change

## Operation
- Reset (async assert, sync release by upstream reset tree): every output is 0, every qualification counter is 0, and every bit is in STABLE.
- Per-bit FSM, two states:
  - STABLE: `sync_dat[i]==filt_dat[i]`, `qcnt=0`.
  - QUAL: input differs from `filt_dat[i]`; `qcnt` counts differing samples.
- Transitions on each `sink_clk` edge, per bit:
  - Input equals `filt_dat`: go to STABLE, `qcnt←0`. Any partial qualification is discarded, which is how glitches are rejected.
  - Input differs and `qcnt==FLT_CNT-1`: `filt_dat[i]` toggles, the matching `rise_pls[i]`/`fall_pls[i]` is set for exactly one cycle, and the bit returns to STABLE with `qcnt←0`.
  - Input differs otherwise: stay in or enter QUAL, `qcnt←qcnt+1`.
- `FLT_CNT=1`: no QUAL dwell. `filt_dat` follows `sync_dat` by one register, and pulses fire on every change.
- `qcnt` width is `$clog2(FLT_CNT)`, minimum 1 bit. It never exceeds `FLT_CNT-1`.
- Sticky flags: set on the corresponding pulse and cleared by `stky_clr`. If set and clear occur in the same cycle, set wins (flag = 1).
- Event counter:
  - Increments by 1 in each cycle where any bit of `rise_pls|fall_pls` is asserted. Multiple bits in the same cycle count as one event.
  - Saturates at all-ones.
  - `evt_clr` with a simultaneous event gives `evt_cnt=1`, so the event is not lost. `evt_clr` alone gives 0.
- Bits are fully independent; there is no cross-bit coupling apart from `evt_cnt`.

## Timing
- Take `sync_dat[i]` as differing from `filt_dat[i]` at consecutive sampling edges E1…E_FLT_CNT. Then `filt_dat[i]` and the pulse become visible right after E_FLT_CNT. Latency is `FLT_CNT` cycles from the first differing sample.
- End-to-end from the asynchronous source: synchronizer depth plus `FLT_CNT` cycles.
- Pulse width is exactly 1 cycle. Minimum spacing between pulses on the same bit is `FLT_CNT` cycles.
- Sticky flags and `evt_cnt` update one cycle after the pulse is visible, because they are registered from the pulse.
- Reset asserted mid-qualification aborts immediately: `filt_dat`, pulses, sticky flags and counter all go to 0 asynchronously. No pulse is generated on reset release.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Package `synch_pkg` holds:
  - the `typedef enum logic {ST_STABLE, ST_QUAL} flt_state_t`;
  - a width helper constant function for `qcnt`.
- Sub-module `synch_glitch_filter`: single-bit FSM, `qcnt`, `filt`, rise/fall pulse. It is instantiated `DAT_WID` times in a generate loop.
- The top level holds the sticky registers, the event counter and the OR-reduction of pulses.

## Test plan
- Reset/default: hold `sink_rst_n=0`, drive `sync_dat=1` → all outputs 0. Release reset with `FLT_CNT=4` → `filt_dat` rises after exactly 4 edges, with `rise_pls` high for 1 cycle and `evt_cnt=1`.
- Glitch rejection: `FLT_CNT=4`, pulse `sync_dat` 1 for 3 cycles then 0 → no change on `filt_dat`, no pulse, `evt_cnt` unchanged.
- Saturation and clear: `EVT_WID=2`, toggle input 5 times with full qualification → `evt_cnt` stops at 3. Assert `evt_clr` in the same cycle as the next pulse → `evt_cnt=1`.
- Sticky priority: `stky_clr` asserted in the cycle the `fall_pls` registers → `fall_stky=1`. `stky_clr` on the next cycle → 0.
- Multi-bit: `DAT_WID=4`, bits 0 and 2 qualify in the same cycle → two pulses and `evt_cnt` +1 only. Bit 3 qualifies later → +1 again.
- Reset mid-qualification: assert `sink_rst_n=0` at `qcnt=2` → outputs 0 immediately. After release with the input still 0 → no pulse.
